// File: rtl/jtframe_cfg_pkg.sv
// Shared types and constants for the OSD configuration scheduler and its reset generator.
package jtframe_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAIT_VB  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_COMMIT   = 3'd4,
        ST_RESET    = 3'd5
    } cfg_state_e;

    localparam logic [63:0] CFG_RST_MASK_DEF = 64'h0000_0000_0000_0001;

    // Well-known status word bit positions used by the DIP decode logic
    localparam int unsigned CFG_BIT_PAUSE  = 1;
    localparam int unsigned CFG_BIT_ASPECT = 2;
    localparam int unsigned CFG_BIT_FX_LO  = 3;
    localparam int unsigned CFG_BIT_FX_HI  = 5;
    localparam int unsigned CFG_BIT_TEST   = 10;

    function automatic logic rst_hit(input logic [63:0] old_w,
                                     input logic [63:0] new_w,
                                     input logic [63:0] mask);
        return |((old_w ^ new_w) & mask);
    endfunction

endpackage

// File: rtl/jtframe_cfg_rstgen.sv
// Reset pulse generator: output held high through async reset and for LEN cycles after it
// deasserts, and for LEN cycles after every load.
module jtframe_cfg_rstgen #(
    parameter int unsigned LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic rst_o,
    output logic last_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 8'(LEN);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'(LEN);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rst_o  = (cnt_q != 8'd0);
    assign last_o = (cnt_q == 8'd1);

endmodule

// File: rtl/jtframe_cfg_sched.sv
// Debounces OSD status changes and commits them at vblank start, pulsing game reset on masked bits.
// Define JTFRAME_CFG_ACK_EN to add the cfg_ack handshake (WAIT_ACK state) before each commit.
module jtframe_cfg_sched
    import jtframe_cfg_pkg::*;
#(
    parameter int unsigned SETTLE   = 4,
    parameter logic [63:0] RST_MASK = CFG_RST_MASK_DEF,
    parameter int unsigned RST_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] status,
    input  logic        vb,
`ifdef JTFRAME_CFG_ACK_EN
    input  logic        cfg_ack,
`endif
    output logic [63:0] status_q,
    output logic        cfg_upd,
    output logic        game_rst,
    output logic        busy
);

    cfg_state_e  state_q, state_d;
    logic [63:0] pend_q, pend_d;
    logic [63:0] commit_q, commit_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        vb_d1_q;
    logic        vb_rise_q;
    logic        rst_load;
    logic        rst_last;
    logic        mismatch;

    assign mismatch = (status != pend_q);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        commit_d = commit_q;
        cnt_d    = cnt_q;
        rst_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (status != commit_q) begin
                    pend_d  = status;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A new value seen on the same cycle as vb_rise restarts the count
                if (status == commit_q) begin
                    state_d = ST_IDLE;
                end else if (mismatch) begin
                    pend_d = status;
                    cnt_d  = 4'd0;
                end else if (vb_rise_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == 4'(SETTLE)) begin
                        state_d = ST_WAIT_VB;
                    end
                end
            end
            ST_WAIT_VB: begin
                if (mismatch) begin
                    pend_d  = status;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else if (vb_rise_q) begin
`ifdef JTFRAME_CFG_ACK_EN
                    state_d = ST_WAIT_ACK;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
`ifdef JTFRAME_CFG_ACK_EN
            ST_WAIT_ACK: begin
                if (mismatch) begin
                    pend_d  = status;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else if (cfg_ack) begin
                    state_d = ST_COMMIT;
                end else if (!vb) begin
                    state_d = ST_WAIT_VB;
                end
            end
`endif
            ST_COMMIT: begin
                commit_d = pend_q;
                if (rst_hit(commit_q, pend_q, RST_MASK)) begin
                    rst_load = 1'b1;
                    state_d  = ST_RESET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESET: begin
                if (rst_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            commit_q  <= '0;
            cnt_q     <= '0;
            vb_d1_q   <= 1'b0;
            vb_rise_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            commit_q  <= commit_d;
            cnt_q     <= cnt_d;
            vb_d1_q   <= vb;
            vb_rise_q <= vb & ~vb_d1_q;
        end
    end

    jtframe_cfg_rstgen #(
        .LEN    (RST_LEN)
    ) u_rstgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (rst_load),
        .rst_o  (game_rst),
        .last_o (rst_last)
    );

    assign status_q = commit_q;
    assign cfg_upd  = (state_q == ST_COMMIT);
    assign busy     = (state_q != ST_IDLE);

endmodule
